// File: rtl/data_bus_pkg.sv
`timescale 1ns/1ps
// data_bus_pkg: shared constants and types for the data-side memory stage.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
//
// Holds the MMIO address map, the UART_STAT bit positions, the store strobe
// encodings, the UART transmitter state type and the misaligned-store check.
package data_bus_pkg;

    // MMIO address map (full 32-bit decode, word granularity)
    localparam logic [31:0] MMIO_BASE      = 32'h1000_0000;
    localparam logic [31:0] UART_DATA_OFS  = 32'h0000_0000;
    localparam logic [31:0] UART_STAT_OFS  = 32'h0000_0004;
    localparam logic [31:0] CYCLE_OFS      = 32'h0000_0008;
    localparam logic [31:0] GPIO_OFS       = 32'h0000_000C;

    localparam logic [31:0] UART_DATA_ADDR = MMIO_BASE + UART_DATA_OFS;
    localparam logic [31:0] UART_STAT_ADDR = MMIO_BASE + UART_STAT_OFS;
    localparam logic [31:0] CYCLE_ADDR     = MMIO_BASE + CYCLE_OFS;
    localparam logic [31:0] GPIO_ADDR      = MMIO_BASE + GPIO_OFS;

    // UART_STAT read bit positions
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    // Store strobes as issued by the core (LSB-justified, before lane shift)
    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // A half-store must sit on an even byte, a word-store on a word boundary.
    function automatic logic store_misaligned(input logic [3:0] strb, input logic [1:0] ofs);
        return ((strb == STRB_HALF) && ofs[0]) ||
               ((strb == STRB_WORD) && (ofs != 2'b00));
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter.
// Latency: a byte pushed into an idle unit is popped the next cycle; its start bit appears on the cycle after that.
// Backpressure: none upstream; a push while full is dropped and latches overflow until clr_ovf.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push_vld, push_dat  byte push strobe and data
//   clr_ovf             clears the sticky overflow flag
//   fifo_full/empty     FIFO occupancy status
//   tx_busy             transmitter is inside a frame (state != IDLE)
//   overflow            sticky dropped-byte flag
//   uart_tx             serial line, idle high, LSB first
module uart_tx_fifo
    import data_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_vld,
    input  logic [7:0] push_dat,
    input  logic       clr_ovf,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       tx_busy,
    output logic       overflow,
    output logic       uart_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   PTR_ONE   = 1;
    localparam logic [BW-1:0] BAUD_ONE  = 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // FIFO: pointers carry one wrap bit so full and empty are distinct.
    // ------------------------------------------------------------------
    logic [7:0]  fifo_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        pop;
    logic        push_ok;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still lands when the transmitter is taking a byte.
    assign push_ok = push_vld && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_vld && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter FSM
    // ------------------------------------------------------------------
    tx_state_t     state;
    tx_state_t     state_nx;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_cnt_nx;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic          tx_q;
    logic          tx_nx;
    logic          baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_cnt_nx;
            bit_idx  <= bit_idx_nx;
            shreg    <= shreg_nx;
            tx_q     <= tx_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        baud_cnt_nx = baud_cnt;
        bit_idx_nx  = bit_idx;
        shreg_nx    = shreg;
        pop         = 1'b0;
        tx_nx       = 1'b1;

        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shreg_nx    = fifo_mem[rd_ptr[AW-1:0]];
                    baud_cnt_nx = '0;
                    state_nx    = TX_START;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    baud_cnt_nx = '0;
                    bit_idx_nx  = '0;
                    state_nx    = TX_DATA;
                end else begin
                    baud_cnt_nx = baud_cnt + BAUD_ONE;
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    baud_cnt_nx = '0;
                    shreg_nx    = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nx = TX_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + BAUD_ONE;
                end
            end
            TX_STOP: begin
                if (baud_done) begin
                    baud_cnt_nx = '0;
                    // Chain straight into the next start bit so frames
                    // are back-to-back with no idle cycle between them.
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shreg_nx = fifo_mem[rd_ptr[AW-1:0]];
                        state_nx = TX_START;
                    end else begin
                        state_nx = TX_IDLE;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + BAUD_ONE;
                end
            end
            default: begin
                state_nx = TX_IDLE;
            end
        endcase

        // Line level is registered alongside the state so the pin never
        // glitches on state or shift-register transitions.
        case (state_nx)
            TX_START: tx_nx = 1'b0;
            TX_DATA:  tx_nx = shreg_nx[0];
            default:  tx_nx = 1'b1;
        endcase
    end

    assign tx_busy = (state != TX_IDLE);
    assign uart_tx = tx_q;

endmodule

// File: rtl/data_bus.sv
`timescale 1ns/1ps
// data_bus: data-side memory stage (word RAM + UART/CYCLE/GPIO MMIO) behind the core's data port.
// Latency: mem_rdata is registered, one cycle after the address; stores commit on the same edge.
// Backpressure: none; an access is accepted every cycle, UART bytes beyond FIFO capacity are dropped and flagged.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mem_addr          byte address, valid every cycle (a read is always performed)
//   mem_wdata         store data, LSB-justified
//   mem_write         store strobes, LSB-justified (0000/0001/0011/1111)
//   mem_rdata         registered read word for the previous cycle's address
//   uart_tx           8N1 serial output, idle high
//   gpio_out          GPIO output register
//   fault_misaligned  sticky misaligned-store flag, cleared only by reset
module data_bus
    import data_bus_pkg::*;
#(
    parameter int DMEM_WORDS    = 4096,
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_write,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic [7:0]  gpio_out,
    output logic        fault_misaligned
);

    localparam int          RAM_AW    = $clog2(DMEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DMEM_WORDS * 4);

    // ------------------------------------------------------------------
    // Decode and lane alignment
    // ------------------------------------------------------------------
    logic [1:0]        byte_ofs;
    logic [31:0]       word_addr;
    logic [3:0]        strb_sh;
    logic [31:0]       wdata_sh;
    logic              misaligned;
    logic              store_ok;
    logic              ram_sel;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_idx;
    logic              mmio_we;
    logic              uart_push;
    logic              stat_wr;
    logic              gpio_wr;

    assign byte_ofs  = mem_addr[1:0];
    assign word_addr = {mem_addr[31:2], 2'b00};
    assign strb_sh   = mem_write << byte_ofs;
    assign wdata_sh  = mem_wdata << {byte_ofs, 3'b000};

    assign misaligned = store_misaligned(mem_write, byte_ofs);
    assign store_ok   = (mem_write != STRB_NONE) && !misaligned && !reset;

    // Full-width compare so addresses past the RAM never alias into it.
    assign ram_sel = (mem_addr < RAM_BYTES);
    assign ram_idx = mem_addr[RAM_AW+1:2];
    assign ram_we  = store_ok && ram_sel;

    // MMIO registers only react when the store covers byte 0 of the word.
    assign mmio_we   = store_ok && strb_sh[0];
    assign uart_push = mmio_we && (word_addr == UART_DATA_ADDR);
    assign stat_wr   = mmio_we && (word_addr == UART_STAT_ADDR);
    assign gpio_wr   = mmio_we && (word_addr == GPIO_ADDR);

    // ------------------------------------------------------------------
    // Data RAM: byte-enabled, read-first, never reset
    // ------------------------------------------------------------------
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] ram_rd_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && strb_sh[b]) begin
                dmem[ram_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
        ram_rd_q <= dmem[ram_idx];
    end

    // ------------------------------------------------------------------
    // UART
    // ------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic tx_busy;
    logic overflow;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DEPTH        (TX_FIFO_DEPTH)
    ) u_uart (
        .clk        (clk),
        .reset      (reset),
        .push_vld   (uart_push),
        .push_dat   (wdata_sh[7:0]),
        .clr_ovf    (stat_wr),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .tx_busy    (tx_busy),
        .overflow   (overflow),
        .uart_tx    (uart_tx)
    );

    // ------------------------------------------------------------------
    // MMIO read mux, CYCLE, GPIO, fault flag, read-data registers
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;
    logic [7:0]  gpio_q;
    logic        fault_q;
    logic [31:0] mmio_rd;
    logic [31:0] mmio_rd_q;
    logic        rd_ram_q;

    always_comb begin
        mmio_rd = '0;
        case (word_addr)
            UART_STAT_ADDR: begin
                mmio_rd[STAT_FULL]  = fifo_full;
                mmio_rd[STAT_EMPTY] = fifo_empty;
                mmio_rd[STAT_BUSY]  = tx_busy;
                mmio_rd[STAT_OVF]   = overflow;
            end
            CYCLE_ADDR: mmio_rd      = cycle_cnt;
            GPIO_ADDR:  mmio_rd[7:0] = gpio_q;
            default:    mmio_rd      = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            gpio_q    <= '0;
            fault_q   <= 1'b0;
            mmio_rd_q <= '0;
            rd_ram_q  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (gpio_wr) begin
                gpio_q <= wdata_sh[7:0];
            end
            if (misaligned) begin
                fault_q <= 1'b1;
            end
            // CYCLE reads capture the value before this edge's increment.
            mmio_rd_q <= mmio_rd;
            rd_ram_q  <= ram_sel;
        end
    end

    // The RAM output register has no reset; the select flop forces the
    // MMIO path (cleared to zero) right after reset.
    assign mem_rdata        = rd_ram_q ? ram_rd_q : mmio_rd_q;
    assign gpio_out         = gpio_q;
    assign fault_misaligned = fault_q;

endmodule
